// File: rtl/clk_division_pkg.sv
// Shared constants and ratio helpers for the runtime-programmable clock divider.
`timescale 1ns/1ps
package clk_division_pkg;

    localparam int unsigned WidthDef = 32;
    localparam int unsigned CntWDef  = 32;
    localparam int unsigned MaxW     = 64;

    // Ratios of 1 or less (zero, negative) all collapse to bypass.
    function automatic logic [MaxW-1:0] sanitize_ratio(input logic signed [MaxW-1:0] ratio);
        return (ratio <= 64'sd1) ? 64'd1 : unsigned'(ratio);
    endfunction

    function automatic logic [MaxW-1:0] high_count(input logic [MaxW-1:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_division_if.sv
// Ratio input and divided-clock outputs of clk_division_unit.
// The tick signal exists only when CLK_DIVISION_TICK_EN is defined.
`timescale 1ns/1ps
interface clk_division_if
    import clk_division_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDef
);
    logic signed [WIDTH-1:0] times;
    logic                    clk_mul;
`ifdef CLK_DIVISION_TICK_EN
    logic                    tick;

    modport master (output times, input clk_mul, input tick);
    modport slave  (input times, output clk_mul, output tick);
`else
    modport master (output times, input clk_mul);
    modport slave  (input times, output clk_mul);
`endif
endinterface

// File: rtl/clk_division_oddstage.sv
// Half-period extension for odd ratios: a negedge copy of the posedge stage ORed back in.
`timescale 1ns/1ps
module clk_division_oddstage (
    input  logic clk_i,
    input  logic rst_i,
    input  logic p_i,
    input  logic odd_i,
    output logic clk_o
);

    logic n_q;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_i;
        end
    end

    assign clk_o = p_i | (n_q & odd_i);

endmodule

// File: rtl/clk_division_unit.sv
// Runtime-programmable 50% duty clock divider; ratio changes apply only at period wrap.
// Optional registered per-period tick output is enabled by defining CLK_DIVISION_TICK_EN.
`timescale 1ns/1ps
module clk_division_unit
    import clk_division_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDef,
    parameter int unsigned CNT_W = CntWDef
) (
    input  logic          clk_i,
    input  logic          rst_i,
    clk_division_if.slave bus
);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic                    load_pending_q;
    logic                    p_q, p_d;
    logic                    odd_q, odd_d;
    logic                    bypass_q, bypass_d;
    logic                    wrap;
    logic                    div_clk;
    logic signed [WIDTH-1:0] times_w;
    logic signed [MaxW-1:0]  times_ext;

    assign times_w   = bus.times;
    assign times_ext = MaxW'(times_w);

    always_comb begin
        wrap  = load_pending_q || (cnt_q == n_q - CNT_W'(1));
        n_d   = n_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (wrap) begin
            n_d   = CNT_W'(sanitize_ratio(times_ext));
            cnt_d = '0;
        end
        bypass_d = (n_d == CNT_W'(1));
        odd_d    = n_d[0] && !bypass_d;
        // Holding p high in bypass keeps the mux inputs equal when leaving bypass at a wrap.
        p_d      = bypass_d || (MaxW'(cnt_d) < high_count(MaxW'(n_d)));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            n_q            <= '0;
            load_pending_q <= 1'b1;
            p_q            <= 1'b0;
            odd_q          <= 1'b0;
            bypass_q       <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            n_q            <= n_d;
            load_pending_q <= 1'b0;
            p_q            <= p_d;
            odd_q          <= odd_d;
            bypass_q       <= bypass_d;
        end
    end

    clk_division_oddstage u_oddstage (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .p_i   (p_q),
        .odd_i (odd_q),
        .clk_o (div_clk)
    );

    assign bus.clk_mul = bypass_q ? clk_i : div_clk;

`ifdef CLK_DIVISION_TICK_EN
    logic tick_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_d == '0);
        end
    end

    assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_division_unit.sv
// Directed bench for clk_division_unit: half-cycle waveform model plus literal period checks.
`timescale 1ns/1ps
module tb_clk_division_unit;

    logic clk;
    logic rst;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  rise_cnt = 0;
    time last_rise   = 0;
    time last_edge   = 0;
    time period_last = 0;
    time high_last   = 0;
    time t_saved     = 0;
    bit  edge_valid  = 1'b0;

    // Model: each output period spans 2*N half-cycles of clk, high for the first N.
    int  n_m     = 1;
    int  hc      = 0;
    bit  started = 1'b0;

    clk_division_if #(.WIDTH(32)) bus ();

    clk_division_unit #(
        .WIDTH (32),
        .CNT_W (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, got, exp);
        end
    endtask

    // Edge monitor: pulse-width floor plus period/high-time capture.
    always @(bus.clk_mul) begin
        if (!rst && edge_valid) begin
            n_checks++;
            if ($time - last_edge >= 20) begin
                n_pass++;
            end else begin
                $display("FAIL min_pulse at %0t: got %0d ns required >= 20 ns", $time,
                         $time - last_edge);
            end
        end
        last_edge  = $time;
        edge_valid = 1'b1;
        if (bus.clk_mul === 1'b1) begin
            period_last = $time - last_rise;
            last_rise   = $time;
            rise_cnt++;
        end else if (bus.clk_mul === 1'b0 && !rst) begin
            high_last = $time - last_rise;
        end
    end

    task automatic sample_half();
        if (rst) begin
            started = 1'b0;
            check("reset_clk_mul", 64'(bus.clk_mul), 64'd0);
`ifdef CLK_DIVISION_TICK_EN
            check("reset_tick", 64'(bus.tick), 64'd0);
`endif
        end else if (started) begin
            check("model_clk_mul", 64'(bus.clk_mul), 64'(hc < n_m));
`ifdef CLK_DIVISION_TICK_EN
            check("model_tick", 64'(bus.tick), 64'(hc < 2));
`endif
            hc++;
        end
    endtask

    initial begin
        int t;
        forever begin
            @(posedge clk);
            if (!rst && (!started || hc >= 2 * n_m)) begin
                t       = bus.times;
                n_m     = (t <= 1) ? 1 : t;
                hc      = 0;
                started = 1'b1;
            end
            #10;
            sample_half();
            @(negedge clk);
            #10;
            sample_half();
        end
    end

    task automatic wait_rises(input int n, input string name);
        int target;
        int k;
        target = rise_cnt + n;
        k      = 0;
        while (rise_cnt < target && k < 12 * n + 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (rise_cnt >= target) begin
            n_pass++;
        end else begin
            $display("FAIL wait_%s: got %0d rises required %0d", name, rise_cnt, target);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.times = 32'sd10;
        #10;
        rst = 1'b0;

        // Divide by 10: first rise at the first posedge (20 ns), 400 ns period.
        wait_rises(1, "first_rise");
        check("first_rise_time", 64'(last_rise), 64'd20);
        wait_rises(1, "div10");
        check("div10_period", 64'(period_last), 64'd400);
        check("div10_high", 64'(high_last), 64'd200);

        // Divide by 7: 280 ns period, 140 ns high, checked after 20 periods.
        #5 bus.times = 32'sd7;
        wait_rises(2, "div7_start");
        check("div7_first_period", 64'(period_last), 64'd280);
        wait_rises(20, "div7_run");
        check("div7_period", 64'(period_last), 64'd280);
        check("div7_high", 64'(high_last), 64'd140);

        // Divide by 4, then switch to 6 while the counter is at 1.
        #5 bus.times = 32'sd4;
        wait_rises(3, "div4_start");
        wait_rises(1, "div4_sync");
        @(posedge clk);
        #25 bus.times = 32'sd6;
        wait_rises(1, "div4_finish");
        check("div4_period_intact", 64'(period_last), 64'd160);
        check("div4_high_intact", 64'(high_last), 64'd80);
        wait_rises(1, "div6_first");
        check("div6_period", 64'(period_last), 64'd240);
        check("div6_high", 64'(high_last), 64'd120);

        // Bypass for 0, 1 and -5, then leave bypass with ratio 2.
        #5 bus.times = 32'sd0;
        wait_rises(3, "bypass0");
        check("bypass0_period", 64'(period_last), 64'd40);
        check("bypass0_high", 64'(high_last), 64'd20);
        #5 bus.times = 32'sd1;
        wait_rises(3, "bypass1");
        check("bypass1_period", 64'(period_last), 64'd40);
        #5 bus.times = -32'sd5;
        wait_rises(3, "bypass_neg");
        check("bypass_neg_period", 64'(period_last), 64'd40);
        check("bypass_neg_high", 64'(high_last), 64'd20);
        #5 bus.times = 32'sd2;
        wait_rises(2, "div2");
        check("div2_period", 64'(period_last), 64'd80);
        check("div2_high", 64'(high_last), 64'd40);

        // Reset for 30 ns while clk_mul is high with ratio 10.
        #5 bus.times = 32'sd10;
        wait_rises(2, "div10_again");
        t_saved = last_rise;
        #25 rst = 1'b1;
        #1;
        check("reset_drop", 64'(bus.clk_mul), 64'd0);
        #29 rst = 1'b0;
        wait_rises(1, "post_reset_rise");
        check("post_reset_rise_time", 64'(last_rise), 64'(t_saved + 80));
        wait_rises(1, "post_reset_period");
        check("post_reset_period", 64'(period_last), 64'd400);

        // Divide by 5: 200 ns period, 100 ns high.
        #5 bus.times = 32'sd5;
        wait_rises(2, "div5_start");
        wait_rises(3, "div5_run");
        check("div5_period", 64'(period_last), 64'd200);
        check("div5_high", 64'(high_last), 64'd100);
`ifdef CLK_DIVISION_TICK_EN
        check("tick_at_rise", 64'(bus.tick), 64'd1);
        @(posedge clk);
        #10;
        check("tick_after_rise", 64'(bus.tick), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
